// File: rtl/fifo_vc.sv
// ---------------------------------------------------------------------------
// fifo_vc -- per-virtual-channel receive FIFO
//
// Buffers words pushed by the upstream demux until the next stage pops them.
// Read data is registered (1 clock after the pop edge). Status flags are
// decoded from the occupancy count.
//
// Optional feature macro: FIFO_VC_ERR_EN
//   defined   -> error is a sticky overflow/underflow flag, cleared by reset
//   undefined -> error is tied low; overflow/underflow are silently ignored
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-low reset (0 = reset)
//   push          in   write request
//   data_in       in   write data (bit 5 is the VC tag, stored unmodified)
//   pop           in   read request
//   data_out      out  registered read data (0 when valid_out=0)
//   valid_out     out  data_out carries a popped word this cycle
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_TH
//   almost_empty  out  count <= AE_TH
//   error         out  sticky overflow/underflow flag (see macro above)
// ---------------------------------------------------------------------------
module fifo_vc #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_TH      = 3,
  parameter int AE_TH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0]         AE_C    = CW'(AE_TH);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  error_q, error_d;
  logic                  pop_ok, push_ok;

  // Status flags decoded from the registered count
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == {CW{1'b0}});
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign error     = error_q;

  // A pop frees a slot in the same edge, so a push at full is still accepted
  // when paired with a pop (full implies non-empty, so that pop is accepted).
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

`ifdef FIFO_VC_ERR_EN
  logic overflow, underflow;
  assign overflow  = push & ~push_ok;
  assign underflow = pop & empty;
`endif

  // Memory write-port next state
  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
  end

  // Pointer, count, read-data and error next state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = {DATA_WIDTH{1'b0}};
    valid_out_d = 1'b0;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end else begin
      rd_ptr_d    = rd_ptr_q;
      data_out_d  = {DATA_WIDTH{1'b0}};
      valid_out_d = 1'b0;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

`ifdef FIFO_VC_ERR_EN
    error_d = error_q | overflow | underflow;
`else
    error_d = 1'b0;
`endif
  end

  // Storage array; contents are don't-care after reset so no reset term
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      count_q     <= {CW{1'b0}};
      data_out_q  <= {DATA_WIDTH{1'b0}};
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_fifo_vc.sv
// ---------------------------------------------------------------------------
// tb_fifo_vc -- scoreboard bench for fifo_vc
//
// The driver applies one set of inputs per clock (at the falling edge) and
// advances a queue-based reference model; every word the model says is popped
// is pushed onto an expected-output queue. A separate monitor samples the DUT
// 1 time unit after each rising edge, matches valid_out words against that
// queue and compares the status flags with the model occupancy.
// ---------------------------------------------------------------------------
module tb_fifo_vc;

  localparam int DW    = 6;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          error;

  fifo_vc dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] fifo_m [$];
  logic [DW-1:0] exp_q  [$];
  logic          err_m;
  bit            mon_en;

  int tests;
  int fails;

  // One clock of stimulus plus the model's view of the following edge
  task automatic drive(input logic rst_v, input logic psh, input logic [DW-1:0] d,
                       input logic pp);
    bit pop_ok;
    bit push_ok;
    @(negedge clk);
    reset   = rst_v;
    push    = psh;
    data_in = d;
    pop     = pp;
    if (!rst_v) begin
      fifo_m.delete();
      err_m = 1'b0;
    end else begin
      pop_ok  = pp && (fifo_m.size() > 0);
      push_ok = psh && ((fifo_m.size() < DEPTH) || pop_ok);
`ifdef FIFO_VC_ERR_EN
      if ((pp && !pop_ok) || (psh && !push_ok)) err_m = 1'b1;
`endif
      if (pop_ok)  exp_q.push_back(fifo_m.pop_front());
      if (push_ok) fifo_m.push_back(d);
    end
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 6'h00, 1'b0);
  endtask

  // Monitor: checks DUT outputs against the scoreboard after every edge
  always @(posedge clk) begin
    logic [DW-1:0] w;
    int            n;
    logic [4:0]    flags_exp;
    logic [4:0]    flags_act;
    #1;
    if (mon_en) begin
      tests++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: data_out=%h valid_out=1, required valid_out=0 at %0t",
                   data_out, $time);
        end else begin
          w = exp_q.pop_front();
          if (data_out !== w) begin
            fails++;
            $display("FAIL pop_data: data_out=%h, required %h at %0t", data_out, w, $time);
          end
        end
      end else begin
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          fails++;
          $display("FAIL missing_valid: valid_out=%b, required 1 with data %h at %0t",
                   valid_out, w, $time);
        end else if (data_out !== 6'h00) begin
          fails++;
          $display("FAIL idle_data: data_out=%h, required 00 at %0t", data_out, $time);
        end
      end

      n = fifo_m.size();
      flags_exp = {(n == DEPTH), (n == 0), (n >= 3), (n <= 1), err_m};
      flags_act = {full, empty, almost_full, almost_empty, error};
      tests++;
      if (flags_act !== flags_exp) begin
        fails++;
        $display("FAIL flags{full,empty,af,ae,err}: got %b, required %b (count %0d) at %0t",
                 flags_act, flags_exp, n, $time);
      end
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    err_m   = 1'b0;
    mon_en  = 1'b0;
    reset   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = 6'h00;

    // 1. Reset held for two clocks
    drive(1'b0, 1'b0, 6'h00, 1'b0);
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 6'h00, 1'b0);

    // 2. Fill and drain
    drive(1'b1, 1'b1, 6'h01, 1'b0);
    drive(1'b1, 1'b1, 6'h02, 1'b0);
    drive(1'b1, 1'b1, 6'h03, 1'b0);
    drive(1'b1, 1'b1, 6'h24, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 6'h00, 1'b1);
    idle();

    // 3. Overflow at full
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 6'(i + 8), 1'b0);
    drive(1'b1, 1'b1, 6'h3F, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 6'h00, 1'b1);
    idle();

    // Clear any sticky error before the no-error full push+pop case
    drive(1'b0, 1'b0, 6'h00, 1'b0);

    // 4. Push+pop together at full
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, 6'(i), 1'b0);
    drive(1'b1, 1'b1, 6'h05, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 6'h00, 1'b1);
    idle();

    // 5. Push+pop together at empty
    drive(1'b1, 1'b1, 6'h2A, 1'b1);
    drive(1'b1, 1'b0, 6'h00, 1'b1);
    idle();

    // 6. Pointer wrap, then reset mid-operation
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 6'(6'h30 + 6'(i)), 1'b0);
      drive(1'b1, 1'b0, 6'h00, 1'b1);
    end
    drive(1'b1, 1'b1, 6'h15, 1'b0);
    drive(1'b1, 1'b1, 6'h16, 1'b0);
    drive(1'b0, 1'b1, 6'h17, 1'b1);
    drive(1'b1, 1'b1, 6'h11, 1'b0);
    drive(1'b1, 1'b0, 6'h00, 1'b1);
    idle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1,
            1'($urandom_range(0, 1)),
            6'($urandom),
            1'($urandom_range(0, 1)));
    end
    idle();
    idle();

    // Nothing the model popped may be left unmatched
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d words outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
